// File: rtl/player_bullet_if.sv
// Bullet pool bus shared between the bullet controller, the enemy controller
// and the renderer: per-slot position/live buses, the per-slot hit feedback
// and the spawn/drop event pulses.
interface player_bullet_if #(
  parameter int BULLET_COUNT = 8
);
  logic [10*BULLET_COUNT-1:0] bullet_x_flat;
  logic [10*BULLET_COUNT-1:0] bullet_y_flat;
  logic [BULLET_COUNT-1:0]    bullet_active_flat;
  logic [BULLET_COUNT-1:0]    bullet_hit;
  logic                       shot_fired;
  logic                       fire_dropped;

  // Bullet controller side: owns the pool, listens for hits.
  modport master (
    output bullet_x_flat,
    output bullet_y_flat,
    output bullet_active_flat,
    output shot_fired,
    output fire_dropped,
    input  bullet_hit
  );

  // Consumer side (enemy controller / renderer): reads the pool, reports hits.
  modport slave (
    input  bullet_x_flat,
    input  bullet_y_flat,
    input  bullet_active_flat,
    input  shot_fired,
    input  fire_dropped,
    output bullet_hit
  );
endinterface

// File: rtl/player_bullet_controller.sv
// Player bullet pool. Synchronises the fire button, spawns bullets at the
// ship muzzle (rate-limited by a cooldown), moves live bullets upward on a
// divided tick, and retires them at the top of the screen or on a hit.
module player_bullet_controller #(
  parameter int BULLET_COUNT = 8,
  parameter int MOVE_DIV     = 65536,
  parameter int BULLET_SPEED = 4,
  parameter int COOLDOWN     = 1_000_000,
  parameter int PLAYER_W     = 32,
  parameter int BULLET_H     = 8
) (
  input  logic                   clk25,
  input  logic                   rst_n,
  input  logic                   fire_btn,
  input  logic [9:0]             player_x,
  input  logic [9:0]             player_y,
  player_bullet_if.master        bus
);

  localparam int IDX_W  = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
  localparam int TICK_W = $clog2(MOVE_DIV);
  localparam int CD_W   = $clog2(COOLDOWN + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(MOVE_DIV - 1);
  localparam logic [CD_W-1:0]   CD_LOAD    = CD_W'(COOLDOWN - 1);
  localparam logic [9:0]        MUZZLE_OFS = 10'(PLAYER_W / 2);
  localparam logic [9:0]        SPEED      = 10'(BULLET_SPEED);
  localparam logic [9:0]        HEIGHT     = 10'(BULLET_H);

  // Muzzle x: centre of the ship, wrapping inside the 10-bit coordinate space.
  function automatic logic [9:0] muzzle_x(input logic [9:0] px);
    return px + MUZZLE_OFS;
  endfunction

  // Spawn y: just above the ship, saturated at the top edge of the screen.
  function automatic logic [9:0] spawn_y(input logic [9:0] py);
    logic [9:0] y;
    if (py < HEIGHT) y = '0;
    else             y = py - HEIGHT;
    return y;
  endfunction

  // Button synchroniser plus one extra flop for edge detection.
  logic fire_s1, fire_s2, fire_s3;

  // Movement divider and spawn cooldown.
  logic [TICK_W-1:0] tick_cnt;
  logic [CD_W-1:0]   cd_cnt;

  // Per-slot state.
  logic [9:0]              x_q [BULLET_COUNT];
  logic [9:0]              y_q [BULLET_COUNT];
  logic [BULLET_COUNT-1:0] active_q;
  logic                    shot_q;
  logic                    drop_q;

  // Decoded control for the current cycle.
  logic             press;
  logic             tick;
  logic             fire_ok;
  logic             spawn;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;

  // Flattened views of the slot arrays for the bus.
  logic [10*BULLET_COUNT-1:0] x_flat;
  logic [10*BULLET_COUNT-1:0] y_flat;

  assign press   = fire_s2 & ~fire_s3;
  assign tick    = (tick_cnt == TICK_LAST);
  assign fire_ok = press && (cd_cnt == '0);
  assign spawn   = fire_ok && free_found;

  // Lowest-index free slot, judged on the active state before this edge, so a
  // slot cleared by a hit this cycle is not reused until the next one.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int j = BULLET_COUNT - 1; j >= 0; j--) begin
      if (!active_q[j]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(j);
      end
    end
  end

  // Bring the asynchronous button into clk25 and keep the previous sample.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      fire_s1 <= 1'b0;
      fire_s2 <= 1'b0;
      fire_s3 <= 1'b0;
    end else begin
      fire_s1 <= fire_btn;
      fire_s2 <= fire_s1;
      fire_s3 <= fire_s2;
    end
  end

  // Free-running movement divider; tick is its terminal count.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Cooldown is armed only by a real spawn; a dropped press leaves it idle.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n)              cd_cnt <= '0;
    else if (spawn)          cd_cnt <= CD_LOAD;
    else if (cd_cnt != '0)   cd_cnt <= cd_cnt - 1'b1;
  end

  // Slot update: spawn into the free slot, otherwise hit beats tick movement.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      for (int j = 0; j < BULLET_COUNT; j++) begin
        x_q[j] <= '0;
        y_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < BULLET_COUNT; j++) begin
        if (spawn && (free_idx == IDX_W'(j))) begin
          active_q[j] <= 1'b1;
          x_q[j]      <= muzzle_x(player_x);
          y_q[j]      <= spawn_y(player_y);
        end else if (active_q[j]) begin
          if (bus.bullet_hit[j]) begin
            active_q[j] <= 1'b0;
          end else if (tick) begin
            if (y_q[j] < SPEED) active_q[j] <= 1'b0;
            else                y_q[j]      <= y_q[j] - SPEED;
          end
        end
      end
    end
  end

  // One-cycle event pulses for an accepted press.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      shot_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      shot_q <= fire_ok && free_found;
      drop_q <= fire_ok && !free_found;
    end
  end

  // Pack slot registers onto the flat buses.
  always_comb begin
    x_flat = '0;
    y_flat = '0;
    for (int j = 0; j < BULLET_COUNT; j++) begin
      x_flat[j*10 +: 10] = x_q[j];
      y_flat[j*10 +: 10] = y_q[j];
    end
  end

  assign bus.bullet_x_flat      = x_flat;
  assign bus.bullet_y_flat      = y_flat;
  assign bus.bullet_active_flat = active_q;
  assign bus.shot_fired         = shot_q;
  assign bus.fire_dropped       = drop_q;

endmodule

// File: tb/tb_player_bullet_controller.sv
// Directed bench for player_bullet_controller with a 4-slot pool, a 4-cycle
// movement tick and a 10-cycle cooldown.
module tb_player_bullet_controller;

  logic       clk25;
  logic       rst_n;
  logic       fire_btn;
  logic [9:0] player_x;
  logic [9:0] player_y;
  int         checks;
  int         errors;
  int         cyc;

  player_bullet_if #(.BULLET_COUNT(4)) bif ();

  player_bullet_controller #(
    .BULLET_COUNT(4),
    .MOVE_DIV(4),
    .BULLET_SPEED(4),
    .COOLDOWN(10),
    .PLAYER_W(32),
    .BULLET_H(8)
  ) dut (
    .clk25(clk25),
    .rst_n(rst_n),
    .fire_btn(fire_btn),
    .player_x(player_x),
    .player_y(player_y),
    .bus(bif)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  // Edges since reset release; movement ticks land on every 4th edge.
  always @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [9:0] sx(input int j);
    return bif.bullet_x_flat[j*10 +: 10];
  endfunction

  function automatic logic [9:0] sy(input int j);
    return bif.bullet_y_flat[j*10 +: 10];
  endfunction

  task automatic step;
    @(posedge clk25);
    #1;
  endtask

  task automatic do_reset;
    rst_n          = 1'b0;
    fire_btn       = 1'b0;
    bif.bullet_hit = '0;
    repeat (2) @(posedge clk25);
    @(negedge clk25);
    rst_n = 1'b1;
  endtask

  // One-cycle button pulse; returns sampled just after the spawn edge.
  task automatic press_and_wait;
    fire_btn = 1'b1;
    step;
    fire_btn = 1'b0;
    step;
    step;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (bif.bullet_active_flat !== 4'b0000) begin
      errors++; $display("FAIL reset_active got %b expected 0000", bif.bullet_active_flat);
    end
    checks++;
    if (bif.bullet_x_flat !== 40'd0 || bif.bullet_y_flat !== 40'd0) begin
      errors++; $display("FAIL reset_xy got x=%h y=%h expected 0", bif.bullet_x_flat, bif.bullet_y_flat);
    end
    checks++;
    if (bif.shot_fired !== 1'b0 || bif.fire_dropped !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got shot=%b drop=%b expected 0 0", bif.shot_fired, bif.fire_dropped);
    end
  endtask

  task automatic test_fire;
    logic [9:0] prev;
    int         cnt;
    logic [9:0] exp_y;
    do_reset;
    player_x = 10'd100;
    player_y = 10'd400;
    fire_btn = 1'b1;
    step;
    step;
    checks++;
    if (bif.bullet_active_flat !== 4'b0000 || bif.shot_fired !== 1'b0) begin
      errors++; $display("FAIL fire_early got active=%b shot=%b expected 0000 0", bif.bullet_active_flat, bif.shot_fired);
    end
    step;
    fire_btn = 1'b0;
    checks++;
    if (bif.bullet_active_flat !== 4'b0001 || bif.shot_fired !== 1'b1) begin
      errors++; $display("FAIL fire_spawn got active=%b shot=%b expected 0001 1", bif.bullet_active_flat, bif.shot_fired);
    end
    checks++;
    if (sx(0) !== 10'd116 || sy(0) !== 10'd392) begin
      errors++; $display("FAIL fire_pos got x=%0d y=%0d expected 116 392", sx(0), sy(0));
    end
    step;
    checks++;
    if (bif.shot_fired !== 1'b0) begin
      errors++; $display("FAIL fire_pulse got shot=%b expected 0", bif.shot_fired);
    end
    prev  = 10'd392;
    exp_y = 10'd392;
    for (int k = 0; k < 4; k++) begin
      exp_y = exp_y - 10'd4;
      cnt   = 0;
      while (sy(0) === prev && cnt < 10) begin
        step;
        cnt++;
      end
      checks++;
      if (sy(0) !== exp_y || bif.bullet_active_flat !== 4'b0001 || sx(0) !== 10'd116) begin
        errors++; $display("FAIL fire_move%0d got y=%0d x=%0d active=%b expected y=%0d x=116 active=0001",
                           k, sy(0), sx(0), bif.bullet_active_flat, exp_y);
      end
      if (k > 0) begin
        checks++;
        if (cnt != 4) begin
          errors++; $display("FAIL fire_tick_period%0d got %0d cycles expected 4", k, cnt);
        end
      end
      prev = sy(0);
    end
  endtask

  task automatic test_cooldown;
    int shots;
    int drops;
    do_reset;
    player_x = 10'd200;
    player_y = 10'd300;
    shots    = 0;
    drops    = 0;
    fire_btn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step;
      if (bif.shot_fired === 1'b1)   shots++;
      if (bif.fire_dropped === 1'b1) drops++;
    end
    fire_btn = 1'b0;
    checks++;
    if (shots != 1 || drops != 0 || bif.bullet_active_flat !== 4'b0001) begin
      errors++; $display("FAIL hold_one_shot got shots=%0d drops=%0d active=%b expected 1 0 0001",
                         shots, drops, bif.bullet_active_flat);
    end
    repeat (3) step;
    press_and_wait;
    checks++;
    if (bif.shot_fired !== 1'b1 || bif.bullet_active_flat !== 4'b0011 || sx(1) !== 10'd216 || sy(1) !== 10'd292) begin
      errors++; $display("FAIL second_spawn got shot=%b active=%b x=%0d y=%0d expected 1 0011 216 292",
                         bif.shot_fired, bif.bullet_active_flat, sx(1), sy(1));
    end
    repeat (2) step;
    press_and_wait;
    checks++;
    if (bif.shot_fired !== 1'b0 || bif.fire_dropped !== 1'b0 || bif.bullet_active_flat !== 4'b0011) begin
      errors++; $display("FAIL cooldown_ignore got shot=%b drop=%b active=%b expected 0 0 0011",
                         bif.shot_fired, bif.fire_dropped, bif.bullet_active_flat);
    end
    repeat (2) step;
    press_and_wait;
    checks++;
    if (bif.shot_fired !== 1'b1 || bif.bullet_active_flat !== 4'b0111) begin
      errors++; $display("FAIL cooldown_expired got shot=%b active=%b expected 1 0111",
                         bif.shot_fired, bif.bullet_active_flat);
    end
  endtask

  task automatic test_full;
    logic [3:0] exp_act;
    do_reset;
    player_x = 10'd50;
    player_y = 10'd450;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (7) step;
      press_and_wait;
      exp_act = 4'((1 << (i + 1)) - 1);
      checks++;
      if (bif.bullet_active_flat !== exp_act || bif.shot_fired !== 1'b1) begin
        errors++; $display("FAIL fill%0d got active=%b shot=%b expected %b 1", i, bif.bullet_active_flat, bif.shot_fired, exp_act);
      end
    end
    repeat (7) step;
    press_and_wait;
    checks++;
    if (bif.fire_dropped !== 1'b1 || bif.shot_fired !== 1'b0 || bif.bullet_active_flat !== 4'b1111) begin
      errors++; $display("FAIL full_drop got drop=%b shot=%b active=%b expected 1 0 1111",
                         bif.fire_dropped, bif.shot_fired, bif.bullet_active_flat);
    end
    step;
    checks++;
    if (bif.fire_dropped !== 1'b0) begin
      errors++; $display("FAIL drop_pulse got drop=%b expected 0", bif.fire_dropped);
    end
    bif.bullet_hit = 4'b0100;
    step;
    bif.bullet_hit = 4'b0000;
    checks++;
    if (bif.bullet_active_flat !== 4'b1011) begin
      errors++; $display("FAIL hit_clear got active=%b expected 1011", bif.bullet_active_flat);
    end
    press_and_wait;
    checks++;
    if (bif.shot_fired !== 1'b1 || bif.bullet_active_flat !== 4'b1111 || sx(2) !== 10'd66 || sy(2) !== 10'd442) begin
      errors++; $display("FAIL refill got shot=%b active=%b x=%0d y=%0d expected 1 1111 66 442",
                         bif.shot_fired, bif.bullet_active_flat, sx(2), sy(2));
    end
  endtask

  task automatic test_top_exit;
    do_reset;
    player_x = 10'd0;
    player_y = 10'd10;
    press_and_wait;
    checks++;
    if (bif.bullet_active_flat !== 4'b0001 || sy(0) !== 10'd2 || sx(0) !== 10'd16) begin
      errors++; $display("FAIL near_top_spawn got active=%b x=%0d y=%0d expected 0001 16 2",
                         bif.bullet_active_flat, sx(0), sy(0));
    end
    step;
    checks++;
    if (bif.bullet_active_flat !== 4'b0000 || sy(0) !== 10'd2) begin
      errors++; $display("FAIL top_retire got active=%b y=%0d expected 0000 2", bif.bullet_active_flat, sy(0));
    end
    player_x = 10'd1020;
    player_y = 10'd4;
    repeat (6) step;
    press_and_wait;
    checks++;
    if (bif.bullet_active_flat !== 4'b0001 || sy(0) !== 10'd0 || sx(0) !== 10'd12) begin
      errors++; $display("FAIL clamp_wrap got active=%b x=%0d y=%0d expected 0001 12 0",
                         bif.bullet_active_flat, sx(0), sy(0));
    end
    repeat (3) step;
    checks++;
    if (bif.bullet_active_flat !== 4'b0000 || sy(0) !== 10'd0) begin
      errors++; $display("FAIL zero_retire got active=%b y=%0d expected 0000 0", bif.bullet_active_flat, sy(0));
    end
  endtask

  task automatic test_hit_tick_spawn;
    logic [9:0] y0_before;
    logic [9:0] y2_before;
    do_reset;
    player_x = 10'd300;
    player_y = 10'd400;
    press_and_wait;
    repeat (7) step;
    press_and_wait;
    repeat (7) step;
    press_and_wait;
    bif.bullet_hit = 4'b0010;
    step;
    bif.bullet_hit = 4'b0000;
    checks++;
    if (bif.bullet_active_flat !== 4'b0101) begin
      errors++; $display("FAIL setup_hit got active=%b expected 0101", bif.bullet_active_flat);
    end
    // Position so the spawn edge coincides with a movement tick.
    while (cyc < 30 || ((cyc + 3) % 4) != 0) step;
    fire_btn = 1'b1;
    step;
    fire_btn = 1'b0;
    step;
    y0_before      = sy(0);
    y2_before      = sy(2);
    bif.bullet_hit = 4'b1001;
    step;
    bif.bullet_hit = 4'b0000;
    checks++;
    if (bif.bullet_active_flat !== 4'b0110 || bif.shot_fired !== 1'b1) begin
      errors++; $display("FAIL combo_active got active=%b shot=%b expected 0110 1", bif.bullet_active_flat, bif.shot_fired);
    end
    checks++;
    if (sx(1) !== 10'd316 || sy(1) !== 10'd392) begin
      errors++; $display("FAIL combo_spawn_pos got x=%0d y=%0d expected 316 392", sx(1), sy(1));
    end
    checks++;
    if (sy(2) !== y2_before - 10'd4 || sy(0) !== y0_before) begin
      errors++; $display("FAIL combo_move got y2=%0d y0=%0d expected %0d %0d",
                         sy(2), sy(0), y2_before - 10'd4, y0_before);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    player_x = 10'd10;
    player_y = 10'd200;
    press_and_wait;
    repeat (7) step;
    press_and_wait;
    checks++;
    if (bif.bullet_active_flat !== 4'b0011 || bif.shot_fired !== 1'b1) begin
      errors++; $display("FAIL pre_reset got active=%b shot=%b expected 0011 1", bif.bullet_active_flat, bif.shot_fired);
    end
    #5;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bif.bullet_active_flat !== 4'b0000 || bif.shot_fired !== 1'b0 || bif.fire_dropped !== 1'b0) begin
      errors++; $display("FAIL async_reset_ctrl got active=%b shot=%b drop=%b expected 0000 0 0",
                         bif.bullet_active_flat, bif.shot_fired, bif.fire_dropped);
    end
    checks++;
    if (bif.bullet_x_flat !== 40'd0 || bif.bullet_y_flat !== 40'd0) begin
      errors++; $display("FAIL async_reset_xy got x=%h y=%h expected 0", bif.bullet_x_flat, bif.bullet_y_flat);
    end
    @(negedge clk25);
    rst_n = 1'b1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    fire_btn       = 1'b0;
    player_x       = '0;
    player_y       = '0;
    bif.bullet_hit = '0;
    test_reset;
    test_fire;
    test_cooldown;
    test_full;
    test_top_exit;
    test_hit_tick_spawn;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
